// File: rtl/route_lookup.sv
// Destination-ID route lookup against an external table, with a 2-entry output
// FIFO of {port, dest, payload}, table update port and saturating drop counter.
module route_lookup #(
  parameter int ADDR_W    = 8,
  parameter int PORT_W    = 3,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [ADDR_W-1:0]    IN_DEST,
  input  logic [PAYLOAD_W-1:0] IN_PAYLOAD,
  output logic [ADDR_W-1:0]    TBL_RADDR,
  input  logic [PORT_W-1:0]    TBL_RDATA,
  output logic [ADDR_W-1:0]    TBL_WADDR,
  output logic [PORT_W-1:0]    TBL_WDATA,
  output logic                 TBL_WE,
  input  logic                 UPD_VALID,
  input  logic [ADDR_W-1:0]    UPD_ADDR,
  input  logic [PORT_W-1:0]    UPD_DATA,
  output logic                 UPD_READY,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [PORT_W-1:0]    OUT_PORT,
  output logic [ADDR_W-1:0]    OUT_DEST,
  output logic [PAYLOAD_W-1:0] OUT_PAYLOAD,
  output logic [15:0]          DROP_CNT
);

  typedef struct packed {
    logic [PORT_W-1:0]    port;
    logic [ADDR_W-1:0]    dest;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t      mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic [15:0] drop_cnt;
  logic        accept, no_route, push, pop;

  // Table is read combinationally in the acceptance cycle; updates win over packets.
  assign TBL_RADDR = IN_DEST;
  assign TBL_WADDR = UPD_ADDR;
  assign TBL_WDATA = UPD_DATA;
  assign TBL_WE    = RST_N && UPD_VALID;
  assign UPD_READY = RST_N;

  assign OUT_VALID = (count != 2'd0);
  assign pop       = OUT_VALID && OUT_READY;
  assign IN_READY  = RST_N && !UPD_VALID && ((count < 2'd2) || pop);
  assign accept    = IN_VALID && IN_READY;
  assign no_route  = &TBL_RDATA;
  assign push      = accept && !no_route;

  assign OUT_PORT    = mem[rd_ptr].port;
  assign OUT_DEST    = mem[rd_ptr].dest;
  assign OUT_PAYLOAD = mem[rd_ptr].payload;
  assign DROP_CNT    = drop_cnt;

  // Storage is not reset; count/pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{port: TBL_RDATA, dest: IN_DEST, payload: IN_PAYLOAD};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      drop_cnt <= 16'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && no_route && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_route_lookup.sv
// Directed bench for route_lookup: behavioral routing table plus a queue
// scoreboard that a separate monitor drains on every output handshake.
module tb_route_lookup;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID, IN_READY;
  logic [7:0]  IN_DEST;
  logic [31:0] IN_PAYLOAD;
  logic [7:0]  TBL_RADDR, TBL_WADDR;
  logic [2:0]  TBL_RDATA, TBL_WDATA;
  logic        TBL_WE;
  logic        UPD_VALID, UPD_READY;
  logic [7:0]  UPD_ADDR;
  logic [2:0]  UPD_DATA;
  logic        OUT_VALID, OUT_READY;
  logic [2:0]  OUT_PORT;
  logic [7:0]  OUT_DEST;
  logic [31:0] OUT_PAYLOAD;
  logic [15:0] DROP_CNT;

  route_lookup #(.ADDR_W(8), .PORT_W(3), .PAYLOAD_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DEST(IN_DEST), .IN_PAYLOAD(IN_PAYLOAD), .TBL_RADDR(TBL_RADDR),
    .TBL_RDATA(TBL_RDATA), .TBL_WADDR(TBL_WADDR), .TBL_WDATA(TBL_WDATA),
    .TBL_WE(TBL_WE), .UPD_VALID(UPD_VALID), .UPD_ADDR(UPD_ADDR),
    .UPD_DATA(UPD_DATA), .UPD_READY(UPD_READY), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_PORT(OUT_PORT), .OUT_DEST(OUT_DEST),
    .OUT_PAYLOAD(OUT_PAYLOAD), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  logic [2:0] tbl [256];
  assign TBL_RDATA = tbl[TBL_RADDR];
  always @(posedge CLK) if (TBL_WE) tbl[TBL_WADDR] <= TBL_WDATA;

  int n_cmp = 0;
  int n_err = 0;
  logic [42:0] sb [$];

  task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected entry.
  always @(negedge CLK) begin
    if (OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out_unexpected: got %0h expected none", {OUT_PORT, OUT_DEST, OUT_PAYLOAD});
      end else begin
        check("out_entry", {OUT_PORT, OUT_DEST, OUT_PAYLOAD}, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic upd(input logic [7:0] a, input logic [2:0] d);
    UPD_VALID = 1'b1; UPD_ADDR = a; UPD_DATA = d;
    @(negedge CLK);
    check("upd_we", TBL_WE, 1);
    check("upd_waddr", TBL_WADDR, a);
    tick();
    UPD_VALID = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [31:0] p, input logic [2:0] port, input bit routed);
    int n;
    n = 0;
    IN_VALID = 1'b1; IN_DEST = d; IN_PAYLOAD = p;
    @(negedge CLK);
    while (!IN_READY && n < 20) begin @(negedge CLK); n++; end
    if (!IN_READY) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got IN_READY=0 expected 1 within 20 cycles");
    end else if (routed) sb.push_back({port, d, p});
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 3'd0;
    RST_N = 1'b0; IN_VALID = 1'b0; IN_DEST = '0; IN_PAYLOAD = '0;
    UPD_VALID = 1'b1; UPD_ADDR = 8'd7; UPD_DATA = 3'd3; OUT_READY = 1'b0;
    tick(); tick();
    @(negedge CLK);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_in_ready", IN_READY, 0);
    check("rst_upd_ready", UPD_READY, 0);
    check("rst_tbl_we", TBL_WE, 0);
    check("rst_drop", DROP_CNT, 0);
    UPD_VALID = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("upd_ready_idle", UPD_READY, 1);
    check("in_ready_idle", IN_READY, 1);
    tick();

    // Single packet, one-cycle latency, gone after the pop.
    upd(8'd5, 3'd2);
    OUT_READY = 1'b1;
    send(8'd5, 32'hA5A5A5A5, 3'd2, 1);
    @(negedge CLK); check("lat_valid", OUT_VALID, 1);
    @(negedge CLK); check("lat_gone", OUT_VALID, 0);
    tick();

    // Backpressure: two fill the FIFO, third waits and enters during a pop.
    upd(8'd10, 3'd3);
    OUT_READY = 1'b0;
    send(8'd10, 32'h11111111, 3'd3, 1);
    send(8'd10, 32'h22222222, 3'd3, 1);
    IN_VALID = 1'b1; IN_DEST = 8'd10; IN_PAYLOAD = 32'h33333333;
    @(negedge CLK);
    check("full_in_ready", IN_READY, 0);
    check("full_head", {OUT_PORT, OUT_DEST, OUT_PAYLOAD}, {3'd3, 8'd10, 32'h11111111});
    tick(); tick();
    @(negedge CLK);
    check("stall_stable", {OUT_PORT, OUT_DEST, OUT_PAYLOAD}, {3'd3, 8'd10, 32'h11111111});
    sb.push_back({3'd3, 8'd10, 32'h33333333});
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("pop_push_ready", IN_READY, 1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("still_valid", OUT_VALID, 1);
    repeat (3) tick();
    @(negedge CLK); check("drained", OUT_VALID, 0);

    // No-route drops and saturation.
    upd(8'd9, 3'd7);
    repeat (3) send(8'd9, 32'hDEAD0000, 3'd7, 0);
    @(negedge CLK);
    check("drop_valid", OUT_VALID, 0);
    check("drop_cnt3", DROP_CNT, 3);
    @(posedge CLK); #1;
    IN_VALID = 1'b1; IN_DEST = 8'd9;
    repeat (65531) @(posedge CLK);
    #1;
    @(negedge CLK); check("drop_fffe", DROP_CNT, 16'hFFFE);
    repeat (3) tick();
    @(negedge CLK); check("drop_sat", DROP_CNT, 16'hFFFF);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;

    // Update priority and old/new entry ordering.
    UPD_VALID = 1'b1; UPD_ADDR = 8'd4; UPD_DATA = 3'd1;
    IN_VALID = 1'b1; IN_DEST = 8'd4; IN_PAYLOAD = 32'h44440001;
    @(negedge CLK);
    check("prio_in_ready", IN_READY, 0);
    check("prio_we", TBL_WE, 1);
    @(posedge CLK); #1;
    UPD_VALID = 1'b0;
    IN_VALID = 1'b0;
    send(8'd4, 32'h44440001, 3'd1, 1);
    upd(8'd4, 3'd6);
    send(8'd4, 32'h44440002, 3'd6, 1);
    repeat (3) tick();

    // Mid-operation reset discards buffered packets.
    upd(8'd20, 3'd5);
    OUT_READY = 1'b0;
    send(8'd20, 32'h20200001, 3'd5, 1);
    send(8'd20, 32'h20200002, 3'd5, 1);
    RST_N = 1'b0;
    sb.delete();
    @(negedge CLK);
    check("rst2_in_ready", IN_READY, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rst2_valid", OUT_VALID, 0);
    check("rst2_drop", DROP_CNT, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    OUT_READY = 1'b1;
    send(8'd20, 32'h20200003, 3'd5, 1);
    repeat (3) tick();
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/route_lookup.md
ROUTE_LOOKUP -- requirements
Module: route_lookup

Interface
REQ-001 Parameter: ADDR_W, 8, destination ID width; equals routing table address width.
REQ-002 Parameter: PORT_W, 3, table entry width, output-port tag; all-ones = no route.
REQ-003 Parameter: PAYLOAD_W, 32, packet payload width.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 IN_VALID  input  1  packet offered.
REQ-007 IN_READY  output  1  packet accepted when IN_VALID && IN_READY at rising edge.
REQ-008 IN_DEST  input  ADDR_W  destination ID.
REQ-009 IN_PAYLOAD  input  PAYLOAD_W  packet body.
REQ-010 TBL_RADDR  output  ADDR_W  table read address; drives table ADDR_1.
REQ-011 TBL_RDATA  input  PORT_W  combinational table read data from D_OUT_1.
REQ-012 TBL_WADDR / TBL_WDATA / TBL_WE  output  ADDR_W / PORT_W / 1  table write port; drives ADDR_IN, D_IN, WE.
REQ-013 UPD_VALID  input  1  table update request.
REQ-014 UPD_ADDR / UPD_DATA  input  ADDR_W / PORT_W  update entry address and value.
REQ-015 UPD_READY  output  1  update accepted when UPD_VALID && UPD_READY.
REQ-016 OUT_VALID  output  1  routed packet available.
REQ-017 OUT_READY  input  1  downstream accepts when OUT_VALID && OUT_READY.
REQ-018 OUT_PORT / OUT_DEST / OUT_PAYLOAD  output  PORT_W / ADDR_W / PAYLOAD_W  head-entry port tag, destination, payload.
REQ-019 DROP_CNT  output  16  count of no-route packets.

Function
REQ-020 TBL_RADDR SHALL equal IN_DEST combinationally at all times; lookup result SHALL be sampled from TBL_RDATA in the acceptance cycle.
REQ-021 Output buffer SHALL be a 2-entry FIFO of {port, dest, payload}; head drives OUT_*; OUT_VALID = (count != 0).
REQ-022 Latency: packet accepted at edge N into empty FIFO SHALL present OUT_VALID=1 after edge N; no combinational IN->OUT path.
REQ-023 IN_READY SHALL be (count < 2 || (OUT_VALID && OUT_READY)) && !UPD_VALID, held 0 during reset.
REQ-024 Full FIFO with simultaneous pop and push SHALL pop head and push new entry in the same edge; count stays 2.
REQ-025 Accepted packet with TBL_RDATA == all-ones SHALL NOT be pushed; DROP_CNT increments by 1, saturating at 0xFFFF.
REQ-026 UPD_READY SHALL equal 1 whenever RST_N=1; update has priority over packet acceptance in the same cycle.
REQ-027 On update acceptance: TBL_WE=1, TBL_WADDR=UPD_ADDR, TBL_WDATA=UPD_DATA combinationally in that cycle; TBL_WE=0 otherwise and during reset.
REQ-028 Ordering: packets accepted before an update's edge SHALL carry old entry; packets accepted after SHALL carry new entry.
REQ-029 FIFO order SHALL be strict; OUT_* SHALL be stable while OUT_VALID && !OUT_READY.
REQ-030 Pointers SHALL wrap modulo 2; count width 2 bits, never exceeds 2.

Reset
REQ-031 RST_N=0 at an edge SHALL clear count, pointers, DROP_CNT to 0; OUT_VALID=0, IN_READY=0, UPD_READY=0, TBL_WE=0.
REQ-032 Reset mid-operation SHALL discard buffered packets; payload storage need not be cleared.
REQ-033 First acceptance possible on first edge with RST_N=1 sampled after reset release.

Verification
REQ-034 Table[5]=2; send dest 5, payload 0xA5A5A5A5, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_PORT=2, OUT_DEST=5, payload matches; gone cycle after.
REQ-035 OUT_READY=0, send 3 packets -> first two accepted, IN_READY=0 on third; raise OUT_READY -> order preserved, third accepted during pop.
REQ-036 Table[9]=7 (PORT_W=3), send dest 9 three times -> no OUT_VALID, DROP_CNT=3; force 65537 drops -> DROP_CNT=0xFFFF.
REQ-037 UPD_VALID with UPD_ADDR=4, UPD_DATA=1 while IN_VALID dest 4 -> IN_READY=0, TBL_WE=1 that cycle; packet accepted next cycle with OUT_PORT=1.
REQ-038 Fill FIFO, assert RST_N=0 one edge -> OUT_VALID=0, DROP_CNT=0, IN_READY=0; after release normal acceptance resumes.
